// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port master: RV32I width codes,
// FSM state encoding and default geometry.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_RD_LAT = 1;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        RESP    = 3'd4
    } dmem_state_e;

    // Stores only have signed widths; unsigned codes are load-only.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_port_master_align.sv
// Combinational lane logic: load byte/halfword extraction with sign/zero
// extension, and sub-word merge of store data into a previously read word.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed lanes and build both load and store views.
    always_comb begin
        byte_s     = 8'd0;
        half_s     = 16'd0;
        load_data  = 32'd0;
        store_word = rd_word;

        case (addr_lo)
            2'd0:    byte_s = rd_word[7:0];
            2'd1:    byte_s = rd_word[15:8];
            2'd2:    byte_s = rd_word[23:16];
            2'd3:    byte_s = rd_word[31:24];
            default: byte_s = 8'd0;
        endcase

        if (addr_lo[1]) begin
            half_s = rd_word[31:16];
        end else begin
            half_s = rd_word[15:0];
        end

        case (funct3)
            F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
            F3_BU:   load_data = {24'd0, byte_s};
            F3_H:    load_data = {{16{half_s[15]}}, half_s};
            F3_HU:   load_data = {16'd0, half_s};
            F3_W:    load_data = rd_word;
            default: load_data = 32'd0;
        endcase

        // Unaddressed lanes come straight from rd_word, so they write back unchanged.
        case (funct3)
            F3_B: begin
                case (addr_lo)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    2'd3:    store_word[31:24] = wdata[7:0];
                    default: store_word        = rd_word;
                endcase
            end
            F3_H: begin
                if (addr_lo[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            F3_W:    store_word = wdata;
            default: store_word = rd_word;
        endcase
    end

endmodule

// File: rtl/dmem_port_master.sv
// Single-outstanding load/store master for a 32-bit BRAM data port with
// fixed read latency; sub-word stores are done as read-modify-write.
module dmem_port_master
    import dmem_pkg::*;
#(
    parameter int RD_LAT = DMEM_RD_LAT,
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              enb,
    output logic              web,
    output logic [ADDR_W-1:0] addrb,
    output logic [31:0]       dinb,
    input  logic [31:0]       doutb
);

    dmem_state_e       state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              enb_q, enb_d;
    logic              web_q, web_d;
    logic [ADDR_W-1:0] addrb_q, addrb_d;
    logic [31:0]       dinb_q, dinb_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        wait_cnt_q, wait_cnt_d;

    logic              accept_s;
    logic              req_err_s;
    logic              misalign_s;
    logic [31:0]       load_data_s;
    logic [31:0]       store_word_s;

    dmem_align u_align (
        .funct3     (funct3_q),
        .addr_lo    (addr_lo_q),
        .rd_word    (doutb),
        .wdata      (wdata_q),
        .load_data  (load_data_s),
        .store_word (store_word_s)
    );

    assign accept_s = req_valid && req_ready_q && (state_q == IDLE);

    // Classify the incoming request as misaligned, out of range or illegal.
    always_comb begin
        case (req_funct3[1:0])
            2'b01:   misalign_s = req_addr[0];
            2'b10:   misalign_s = (req_addr[1:0] != 2'd0);
            default: misalign_s = 1'b0;
        endcase
        req_err_s = misalign_s
                 || ((req_addr >> (ADDR_W + 2)) != 32'd0)
                 || !f3_legal(req_we, req_funct3);
    end

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d     = state_q;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        enb_d       = 1'b0;
        web_d       = 1'b0;
        addrb_d     = addrb_q;
        dinb_d      = dinb_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        wdata_d     = wdata_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    we_d      = req_we;
                    funct3_d  = req_funct3;
                    addr_lo_d = req_addr[1:0];
                    wdata_d   = req_wdata;
                    addrb_d   = req_addr[ADDR_W+1:2];
                    if (req_err_s) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        state_d = WR;
                        enb_d   = 1'b1;
                        web_d   = 1'b1;
                        dinb_d  = req_wdata;
                    end else begin
                        state_d = RD;
                        enb_d   = 1'b1;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            RD: begin
                state_d    = RD_WAIT;
                wait_cnt_d = 2'(RD_LAT - 1);
            end
            RD_WAIT: begin
                // doutb is valid in the last wait cycle; sub-word stores write back next.
                if (wait_cnt_q == 2'd0) begin
                    if (we_q) begin
                        state_d = WR;
                        enb_d   = 1'b1;
                        web_d   = 1'b1;
                        dinb_d  = store_word_s;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = load_data_s;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            WR: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = 32'd0;
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            enb_q       <= 1'b0;
            web_q       <= 1'b0;
            addrb_q     <= '0;
            dinb_q      <= 32'd0;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            addr_lo_q   <= 2'd0;
            wdata_q     <= 32'd0;
            wait_cnt_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            enb_q       <= enb_d;
            web_q       <= web_d;
            addrb_q     <= addrb_d;
            dinb_q      <= dinb_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            wdata_q     <= wdata_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign enb       = enb_q;
    assign web       = web_q;
    assign addrb     = addrb_q;
    assign dinb      = dinb_q;

endmodule

// File: tb/tb_dmem_port_master.sv
// Scoreboard bench: two DUTs (RD_LAT 1 and 2) with BRAM models, random and
// directed requests checked against a word-array reference model.
module tb_dmem_port_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid_s [2];
    logic        req_we_s;
    logic [2:0]  req_funct3_s;
    logic [31:0] req_addr_s;
    logic [31:0] req_wdata_s;
    logic        req_ready_s [2];
    logic        rsp_valid_s [2];
    logic        rsp_err_s   [2];
    logic [31:0] rsp_rdata_s [2];
    logic        enb_s       [2];
    logic        web_s       [2];
    logic [9:0]  addrb_s     [2];
    logic [31:0] dinb_s      [2];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          inst;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } resp_t;

    typedef struct {
        int          inst;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] data;
        int          due;
    } strobe_t;

    resp_t       resp_q [$];
    strobe_t     strb_q [$];
    logic [31:0] ref_mem [2][1024];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] t;
        t = 32'(i);
        return (t * 32'h9E3779B9) ^ 32'h0F1E2D3C;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [31:0] mem [1024];
        logic [31:0] pipe0;
        logic [31:0] pipe1;
        logic [31:0] doutb_g;

        initial for (int i = 0; i < 1024; i++) mem[i] = init_word(i);

        // Read data is only meaningful in its valid cycle; other cycles show a poison word.
        always @(posedge clk) begin
            if (enb_s[g] && web_s[g]) mem[addrb_s[g]] <= dinb_s[g];
            pipe0 <= (enb_s[g] && !web_s[g]) ? mem[addrb_s[g]] : 32'hBADC0DE5;
            pipe1 <= pipe0;
        end
        assign doutb_g = (g == 0) ? pipe0 : pipe1;

        dmem_port_master #(.RD_LAT(g + 1), .ADDR_W(10)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid_s[g]),
            .req_ready  (req_ready_s[g]),
            .req_we     (req_we_s),
            .req_funct3 (req_funct3_s),
            .req_addr   (req_addr_s),
            .req_wdata  (req_wdata_s),
            .rsp_valid  (rsp_valid_s[g]),
            .rsp_rdata  (rsp_rdata_s[g]),
            .rsp_err    (rsp_err_s[g]),
            .enb        (enb_s[g]),
            .web        (web_s[g]),
            .addrb      (addrb_s[g]),
            .dinb       (dinb_s[g]),
            .doutb      (doutb_g)
        );
    end

    // Reference model: RV32I load/store semantics on a plain word array.
    function automatic void model(input int d, input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic err, output logic [31:0] rdata,
                                  output logic [31:0] new_word, output int lat,
                                  output logic rmw);
        int          size;
        int          lane;
        int          idx;
        logic        legal;
        logic [31:0] word;
        logic [31:0] v;
        logic [31:0] mask;
        size  = 1 << f3[1:0];
        lane  = int'(addr % 32'd4);
        idx   = int'((addr / 32'd4) % 32'd1024);
        legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                   : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        err      = !legal || ((addr % 32'(size)) != 32'd0) || (addr >= 32'd4096);
        rdata    = 32'd0;
        new_word = 32'd0;
        rmw      = 1'b0;
        word     = ref_mem[d][idx];
        if (err) begin
            lat = 1;
        end else if (!we) begin
            lat = 3 + d;
            v = word >> (8 * lane);
            if (size == 1) begin
                v = v % 32'd256;
                if (!f3[2] && v >= 32'd128) v = v - 32'd256;
            end else if (size == 2) begin
                v = v % 32'd65536;
                if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
            end
            rdata = v;
        end else if (size == 4) begin
            lat      = 2;
            new_word = wdata;
            ref_mem[d][idx] = new_word;
        end else begin
            lat      = 4 + d;
            rmw      = 1'b1;
            mask     = ((32'd1 << (8 * size)) - 32'd1) << (8 * lane);
            new_word = (word & ~mask) | ((wdata << (8 * lane)) & mask);
            ref_mem[d][idx] = new_word;
        end
    endfunction

    task automatic drive_junk(input int d);
        req_valid_s[d] = 1'($urandom_range(0, 1));
        req_we_s       = 1'($urandom_range(0, 1));
        req_funct3_s   = 3'($urandom_range(0, 7));
        req_addr_s     = $urandom;
        req_wdata_s    = $urandom;
    endtask

    // Called at a negedge; garbage is driven on req_* while the DUT is busy.
    task automatic issue(input int d, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        logic        err;
        logic        rmw;
        logic [31:0] rdata;
        logic [31:0] nw;
        int          lat;
        int          k;
        int          guard;
        resp_t       r;
        strobe_t     s;
        guard = 0;
        while (req_ready_s[d] !== 1'b1 && guard < 40) begin
            drive_junk(d);
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_wait inst %0d: req_ready=%b, required 1", d, req_ready_s[d]);
            req_valid_s[d] = 1'b0;
            return;
        end
        model(d, we, f3, addr, wdata, err, rdata, nw, lat, rmw);
        req_valid_s[d] = 1'b1;
        req_we_s       = we;
        req_funct3_s   = f3;
        req_addr_s     = addr;
        req_wdata_s    = wdata;
        r.inst = d; r.err = err; r.rdata = rdata; r.due = cyc + lat;
        resp_q.push_back(r);
        if (!err) begin
            if (!we || rmw) begin
                s.inst = d; s.we = 1'b0; s.addr = addr[11:2]; s.data = 32'd0; s.due = cyc + 1;
                strb_q.push_back(s);
            end
            if (we) begin
                s.inst = d; s.we = 1'b1; s.addr = addr[11:2]; s.data = nw;
                s.due = rmw ? cyc + 3 + d : cyc + 1;
                strb_q.push_back(s);
            end
        end
        @(posedge clk);
        #1;
        req_valid_s[d] = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (req_ready_s[d] !== 1'b1) drive_junk(d);
        end while (req_ready_s[d] !== 1'b1 && k < 40);
        req_valid_s[d] = 1'b0;
        n_checks++;
        if (k != lat + 1) begin
            n_errors++;
            $display("FAIL ready_latency inst %0d f3=%0d we=%0b addr=%h: ready after %0d cycles, required %0d",
                     d, f3, we, addr, k, lat + 1);
        end
    endtask

    task automatic random_ops(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(12, 31));
            else if ($urandom_range(0, 9) == 0) a = 32'hFFC + 32'($urandom_range(0, 3));
            issue(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        n_checks++;
        if (req_ready_s[d] !== 1'b0 || rsp_valid_s[d] !== 1'b0 || rsp_err_s[d] !== 1'b0 ||
            enb_s[d] !== 1'b0 || web_s[d] !== 1'b0 || addrb_s[d] !== 10'd0 ||
            dinb_s[d] !== 32'd0 || rsp_rdata_s[d] !== 32'd0) begin
            n_errors++;
            $display("FAIL %s inst %0d: rdy=%b vld=%b err=%b enb=%b web=%b addrb=%h dinb=%h rdata=%h, required all 0",
                     tag, d, req_ready_s[d], rsp_valid_s[d], rsp_err_s[d], enb_s[d], web_s[d],
                     addrb_s[d], dinb_s[d], rsp_rdata_s[d]);
        end
    endtask

    task automatic check_ready(input int d, input string tag);
        n_checks++;
        if (req_ready_s[d] !== 1'b1) begin
            n_errors++;
            $display("FAIL %s inst %0d: req_ready=%b, required 1", tag, d, req_ready_s[d]);
        end
    endtask

    // SB interrupted by reset in its second cycle must never write or respond.
    task automatic reset_mid_access(input int d);
        strobe_t s;
        int      guard;
        guard = 0;
        while (req_ready_s[d] !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        req_valid_s[d] = 1'b1;
        req_we_s       = 1'b1;
        req_funct3_s   = 3'b000;
        req_addr_s     = 32'h21;
        req_wdata_s    = 32'hA5;
        s.inst = d; s.we = 1'b0; s.addr = 10'd8; s.data = 32'd0; s.due = cyc + 1;
        strb_q.push_back(s);
        @(posedge clk);
        #1;
        req_valid_s[d] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs(d, "reset_async");
        n_checks++;
        if (strb_q.size() != 0) begin
            n_errors++;
            $display("FAIL rmw_read_strobe inst %0d: %0d strobes outstanding, required 0", d, strb_q.size());
        end
        strb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_ready(d, "ready_after_release");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (enb_s[d] !== 1'b0 || rsp_valid_s[d] !== 1'b0) begin
                n_errors++;
                $display("FAIL abandoned inst %0d: enb=%b rsp_valid=%b, required 0 0", d, enb_s[d], rsp_valid_s[d]);
            end
        end
    endtask

    // Monitor: every response and every BRAM strobe is matched against the queues.
    always @(negedge clk) begin
        resp_t   r;
        strobe_t s;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (rsp_valid_s[d] === 1'b1) begin
                    n_checks++;
                    if (resp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL rsp_unexpected inst %0d: rsp_valid=1 err=%b rdata=%h, required no response",
                                 d, rsp_err_s[d], rsp_rdata_s[d]);
                    end else begin
                        r = resp_q.pop_front();
                        if (r.inst != d || r.err !== rsp_err_s[d] || r.rdata !== rsp_rdata_s[d] || r.due != cyc) begin
                            n_errors++;
                            $display("FAIL rsp inst %0d: got err=%b rdata=%h cyc=%0d, required inst %0d err=%b rdata=%h cyc=%0d",
                                     d, rsp_err_s[d], rsp_rdata_s[d], cyc, r.inst, r.err, r.rdata, r.due);
                        end
                    end
                end
                if (enb_s[d] === 1'b1) begin
                    n_checks++;
                    if (strb_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL strobe_unexpected inst %0d: enb=1 web=%b addrb=%h, required no strobe",
                                 d, web_s[d], addrb_s[d]);
                    end else begin
                        s = strb_q.pop_front();
                        if (s.inst != d || s.we !== web_s[d] || s.addr !== addrb_s[d] || s.due != cyc ||
                            (s.we && s.data !== dinb_s[d])) begin
                            n_errors++;
                            $display("FAIL strobe inst %0d: got web=%b addrb=%h dinb=%h cyc=%0d, required inst %0d web=%b addrb=%h dinb=%h cyc=%0d",
                                     d, web_s[d], addrb_s[d], dinb_s[d], cyc, s.inst, s.we, s.addr, s.data, s.due);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        n_errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        int guard;
        rst_n          = 1'b0;
        req_valid_s[0] = 1'b0;
        req_valid_s[1] = 1'b0;
        req_we_s       = 1'b0;
        req_funct3_s   = 3'd0;
        req_addr_s     = 32'd0;
        req_wdata_s    = 32'd0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 1024; i++) ref_mem[d][i] = init_word(i);

        repeat (3) @(negedge clk);
        check_idle_outputs(0, "reset_state");
        check_idle_outputs(1, "reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        check_ready(0, "ready_after_reset");
        check_ready(1, "ready_after_reset");

        issue(0, 1'b1, 3'b010, 32'h010, 32'hDEADBEEF);
        issue(0, 1'b0, 3'b000, 32'h013, 32'd0);
        issue(0, 1'b0, 3'b100, 32'h013, 32'd0);
        issue(0, 1'b1, 3'b001, 32'h012, 32'h00001234);
        issue(0, 1'b0, 3'b010, 32'h010, 32'd0);
        issue(0, 1'b0, 3'b010, 32'h006, 32'd0);
        issue(0, 1'b1, 3'b000, 32'h00001000, 32'd0);
        issue(0, 1'b0, 3'b001, 32'h011, 32'd0);
        issue(0, 1'b0, 3'b101, 32'hFFE, 32'd0);
        issue(0, 1'b0, 3'b011, 32'h000, 32'd0);
        issue(0, 1'b1, 3'b100, 32'h004, 32'd0);
        issue(0, 1'b1, 3'b000, 32'h011, 32'hFFFFFF7E);
        issue(0, 1'b0, 3'b010, 32'h010, 32'd0);
        random_ops(0, 150);
        reset_mid_access(0);
        issue(0, 1'b0, 3'b010, 32'h020, 32'd0);

        issue(1, 1'b1, 3'b010, 32'h010, 32'hDEADBEEF);
        issue(1, 1'b0, 3'b001, 32'h010, 32'd0);
        issue(1, 1'b0, 3'b101, 32'h012, 32'd0);
        issue(1, 1'b1, 3'b000, 32'h012, 32'h00000055);
        issue(1, 1'b0, 3'b010, 32'h010, 32'd0);
        random_ops(1, 150);

        guard = 0;
        while ((resp_q.size() != 0 || strb_q.size() != 0) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (resp_q.size() != 0 || strb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d responses and %0d strobes outstanding, required 0 and 0",
                     resp_q.size(), strb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
